// File: rtl/fns_cac_link_3_6.sv
// Fault-tolerant crosstalk-avoidance link over 9 TSVs.
// Data is mapped onto the enabled TSVs with a locally adaptive Fibonacci
// numeral system (FNS) code. The code never drives an enabled odd TSV to 1
// while an adjacent enabled even TSV is 0. Faulty TSVs are held at 0 and are
// left out of the code. The sender encodes datain and registers it. The
// receiver rebuilds the weights from the registered enable flags and decodes.
module fns_cac_link_3_6 #(
  parameter int DATA_W = 2,   // data width; 2 always fits with up to 6 faults
  parameter int N_TSV  = 9,   // TSV count; only 9 is supported
  parameter int CW     = 10   // weight/count width, holds up to 512
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [N_TSV-1:0]  f_flag,
  input  logic [DATA_W-1:0] datain,
  output logic [N_TSV-1:0]  tsv,
  output logic [N_TSV-1:0]  en_flag,
  output logic [DATA_W-1:0] dataout,
  output logic              overflow
);

  // Per-TSV FNS weights plus the code capacity for one enable map.
  typedef struct packed {
    logic [N_TSV-1:0][CW-1:0] w;
    logic [CW-1:0]            cap;
  } weights_t;

  // FNS adder chain. a0 and a1 count the legal assignments of TSVs 0..j.
  // a0 covers TSV j+1 = 0 and a1 covers TSV j+1 = 1. s counts all of them.
  // The weight of TSV j is the count below it when TSV j is 0.
  function automatic weights_t calc_weights(input logic [N_TSV-1:0] e);
    weights_t      res;
    logic [N_TSV:0] e_ext;
    logic [CW-1:0] s, a0, a1, s_n, a0_n, a1_n;
    res   = '0;
    e_ext = {1'b0, e};   // virtual TSV above the top is never enabled
    s     = CW'(1);
    a0    = CW'(1);
    a1    = CW'(1);
    for (int k = 1; k <= N_TSV; k++) begin
      res.w[k-1] = a0;
      if (!e_ext[k-1]) begin
        // Disabled TSV: it adds nothing and puts no constraint on TSV k.
        s_n  = s;
        a0_n = s;
        a1_n = s;
      end else begin
        s_n = a0 + a1;
        if (e_ext[k]) begin
          if ((k - 1) % 2 == 0) begin
            // Even TSV below an enabled odd TSV: odd = 1 forces even = 1.
            a0_n = a0 + a1;
            a1_n = a1;
          end else begin
            // Odd TSV below an enabled even TSV: even = 0 forces odd = 0.
            a0_n = a0;
            a1_n = a0 + a1;
          end
        end else begin
          a0_n = s_n;
          a1_n = s_n;
        end
      end
      s  = s_n;
      a0 = a0_n;
      a1 = a1_n;
    end
    res.cap = s;
    return res;
  endfunction

  weights_t          w_tx;
  weights_t          w_rx;
  logic [N_TSV-1:0]  w_code;
  logic              w_ovf;
  logic [CW-1:0]     w_dec_sum;
  logic              w_unused;

  logic [N_TSV-1:0]  r_tsv;
  logic [N_TSV-1:0]  r_en_flag;
  logic              r_overflow;

  // The sender uses the live fault map. The receiver uses the registered map
  // that goes with r_tsv, so a flag change between edges cannot corrupt dataout.
  assign w_tx = calc_weights(~f_flag);
  assign w_rx = calc_weights(r_en_flag);

  // Greedy FNS encode from TSV 8 down to TSV 0. A bit forced by the TSV above
  // takes the forced value and subtracts nothing.
  always_comb begin : encode
    logic [CW-1:0]  rem;
    logic [N_TSV:0] en_ext;
    logic [N_TSV:0] code_ext;
    // NOTE: every variable gets a value before any branch reads it. A path
    // that skips an assignment would infer a latch.
    rem      = CW'(datain);
    en_ext   = {1'b0, ~f_flag};
    code_ext = '0;
    w_ovf    = (CW'(datain) >= w_tx.cap);
    for (int k = N_TSV - 1; k >= 0; k--) begin
      // NOTE: rem and code_ext are scratch values inside one combinational
      // pass. Blocking assignment lets each step see the previous step's result.
      if (!en_ext[k]) begin
        code_ext[k] = 1'b0;
      end else if (en_ext[k+1] && (k % 2 == 0) && code_ext[k+1]) begin
        code_ext[k] = 1'b1;
      end else if (en_ext[k+1] && (k % 2 == 1) && !code_ext[k+1]) begin
        code_ext[k] = 1'b0;
      end else if (rem >= w_tx.w[k]) begin
        code_ext[k] = 1'b1;
        rem         = rem - w_tx.w[k];
      end else begin
        code_ext[k] = 1'b0;
      end
    end
    w_code = w_ovf ? '0 : code_ext[N_TSV-1:0];
  end

  // Register the codeword with the enable map and the overflow flag that
  // produced it.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_tsv      <= '0;
      r_en_flag  <= '0;
      r_overflow <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignment. Every register then samples
      // values from before the edge, whatever order the statements are in.
      r_tsv      <= w_code;
      r_en_flag  <= ~f_flag;
      r_overflow <= w_ovf;
    end
  end

  // Decode: add the weights of set, enabled bits that were not forced to 1
  // by the enabled odd TSV above them.
  always_comb begin : decode
    logic [N_TSV:0] en_ext;
    logic [N_TSV:0] tsv_ext;
    en_ext    = {1'b0, r_en_flag};
    tsv_ext   = {1'b0, r_tsv};
    w_dec_sum = '0;
    for (int k = 0; k < N_TSV; k++) begin
      if (en_ext[k] && tsv_ext[k] &&
          !((k % 2 == 0) && en_ext[k+1] && tsv_ext[k+1])) begin
        w_dec_sum = w_dec_sum + w_rx.w[k];
      end
    end
  end

  // The decoded sum is truncated to DATA_W bits. The receiver does not need
  // the capacity.
  assign w_unused = ^{w_dec_sum[CW-1:DATA_W], w_rx.cap};

  assign tsv      = r_tsv;
  assign en_flag  = r_en_flag;
  assign overflow = r_overflow;
  assign dataout  = w_dec_sum[DATA_W-1:0];

endmodule

// File: tb/tb_fns_cac_link_3_6.sv
// Testbench for fns_cac_link_3_6. The reference model lists every legal
// codeword of a fault map in ascending order. The codeword for value d is
// entry d of that list, and the capacity is the length of the list.
module tb_fns_cac_link_3_6;

  localparam int DATA_W = 2;
  localparam int N_TSV  = 9;

  logic              clock = 1'b0;
  logic              rst_n;
  logic [N_TSV-1:0]  f_flag;
  logic [DATA_W-1:0] datain;
  logic [N_TSV-1:0]  tsv;
  logic [N_TSV-1:0]  en_flag;
  logic [DATA_W-1:0] dataout;
  logic              overflow;

  int n_vec = 0;
  int n_err = 0;

  fns_cac_link_3_6 #(.DATA_W(DATA_W), .N_TSV(N_TSV), .CW(10)) dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .f_flag   (f_flag),
    .datain   (datain),
    .tsv      (tsv),
    .en_flag  (en_flag),
    .dataout  (dataout),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  // Checks that no adjacent enabled pair has the odd TSV at 1 and the even TSV at 0.
  function automatic bit legal(input logic [8:0] c, input logic [8:0] e);
    for (int k = 0; k < 8; k++) begin
      if (e[k] && e[k+1]) begin
        if (k % 2 == 1) begin
          if (c[k] && !c[k+1]) return 1'b0;
        end else begin
          if (c[k+1] && !c[k]) return 1'b0;
        end
      end
    end
    return 1'b1;
  endfunction

  // Reference model: code = the d-th legal word (faulty TSVs at 0), counting from 0.
  function automatic void model(input logic [8:0] f, input int d,
                                output logic [8:0] code, output bit ovf);
    int         cnt;
    logic [8:0] c;
    cnt  = 0;
    code = '0;
    ovf  = 1'b1;
    for (int v = 0; v < 512; v++) begin
      c = 9'(v);
      if ((c & f) == 9'd0 && legal(c, ~f)) begin
        if (cnt == d) begin
          code = c;
          ovf  = 1'b0;
        end
        cnt++;
      end
    end
  endfunction

  task automatic apply(input logic [8:0] f, input logic [1:0] d);
    f_flag = f;
    datain = d;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    f_flag = '0;
    datain = '0;
    #12;
    n_vec += 4;
    if (tsv !== 9'd0)      begin n_err++; $display("FAIL reset_tsv: got %b want 0", tsv); end
    if (en_flag !== 9'd0)  begin n_err++; $display("FAIL reset_en: got %b want 0", en_flag); end
    if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    if (dataout !== 2'd0)  begin n_err++; $display("FAIL reset_dout: got %0d want 0", dataout); end
    @(negedge clock);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [8:0] tf [9] = '{9'h000, 9'h000, 9'h000, 9'h000, 9'b111111000,
                           9'b111110001, 9'b111110001, 9'h1FF, 9'h1FF};
    logic [1:0] td [9] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    logic [8:0] tt [9] = '{9'b000000101, 9'b000000100, 9'b000000001, 9'b0,
                           9'b000000101, 9'b000001100, 9'b000000110, 9'b0, 9'b0};
    logic [1:0] to [9] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd3, 2'd2, 2'd0, 2'd0};
    logic       tv [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      apply(tf[i], td[i]);
      n_vec += 4;
      if (tsv !== tt[i]) begin
        n_err++; $display("FAIL dir%0d_tsv: got %b want %b", i, tsv, tt[i]);
      end
      if (dataout !== to[i]) begin
        n_err++; $display("FAIL dir%0d_dout: got %0d want %0d", i, dataout, to[i]);
      end
      if (overflow !== tv[i]) begin
        n_err++; $display("FAIL dir%0d_ovf: got %b want %b", i, overflow, tv[i]);
      end
      if (en_flag !== ~tf[i]) begin
        n_err++; $display("FAIL dir%0d_en: got %b want %b", i, en_flag, ~tf[i]);
      end
    end
  endtask

  task automatic test_flag_hold();
    apply(9'h000, 2'd3);
    #2;
    f_flag = 9'h1FF;
    datain = 2'd1;
    #1;
    n_vec += 3;
    if (dataout !== 2'd3) begin n_err++; $display("FAIL hold_dout: got %0d want 3", dataout); end
    if (en_flag !== 9'h1FF) begin n_err++; $display("FAIL hold_en: got %b want 111111111", en_flag); end
    if (tsv !== 9'b000000101) begin n_err++; $display("FAIL hold_tsv: got %b want 000000101", tsv); end
    @(posedge clock);
    #1;
    n_vec += 3;
    if (overflow !== 1'b1) begin n_err++; $display("FAIL hold_ovf: got %b want 1", overflow); end
    if (tsv !== 9'd0)      begin n_err++; $display("FAIL hold_tsv0: got %b want 0", tsv); end
    if (dataout !== 2'd0)  begin n_err++; $display("FAIL hold_dout0: got %0d want 0", dataout); end
  endtask

  task automatic test_async_reset();
    apply(9'h000, 2'd3);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec += 4;
    if (tsv !== 9'd0)      begin n_err++; $display("FAIL arst_tsv: got %b want 0", tsv); end
    if (en_flag !== 9'd0)  begin n_err++; $display("FAIL arst_en: got %b want 0", en_flag); end
    if (overflow !== 1'b0) begin n_err++; $display("FAIL arst_ovf: got %b want 0", overflow); end
    if (dataout !== 2'd0)  begin n_err++; $display("FAIL arst_dout: got %0d want 0", dataout); end
    @(posedge clock);
    #1;
    n_vec++;
    if (tsv !== 9'd0) begin n_err++; $display("FAIL arst_hold: got %b want 0", tsv); end
    #2;
    rst_n = 1'b1;
    apply(9'h000, 2'd2);
    n_vec += 2;
    if (tsv !== 9'b000000100) begin n_err++; $display("FAIL arst_resume_tsv: got %b want 000000100", tsv); end
    if (dataout !== 2'd2)     begin n_err++; $display("FAIL arst_resume_dout: got %0d want 2", dataout); end
  endtask

  task automatic test_random();
    logic [8:0] f;
    logic [1:0] d;
    logic [8:0] code;
    bit         ovf;
    int         idx;
    for (int r = 0; r < 500; r++) begin
      f = '0;
      for (int step = 0; step <= 6; step++) begin
        for (int n = 0; n < 10; n++) begin
          d = 2'($urandom_range(3, 0));
          apply(f, d);
          model(f, int'(d), code, ovf);
          n_vec += 5;
          if (tsv !== code) begin
            n_err++; $display("FAIL rnd_tsv f=%b d=%0d: got %b want %b", f, d, tsv, code);
          end
          if (overflow !== ovf) begin
            n_err++; $display("FAIL rnd_ovf f=%b d=%0d: got %b want %b", f, d, overflow, ovf);
          end
          if (en_flag !== ~f) begin
            n_err++; $display("FAIL rnd_en f=%b: got %b want %b", f, en_flag, ~f);
          end
          if (!ovf && dataout !== d) begin
            n_err++; $display("FAIL rnd_dout f=%b: got %0d want %0d", f, dataout, d);
          end
          if (!legal(tsv, en_flag)) begin
            n_err++; $display("FAIL rnd_pattern f=%b: got tsv %b want no forbidden pair", f, tsv);
          end
        end
        if (step < 6) begin
          do idx = $urandom_range(8, 0); while (f[idx]);
          f[idx] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flag_hold();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
